// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and control_unit: widths, opcodes,
// the halt word and the fetch FSM state encoding.
package cpu_pkg;

  localparam int SIZE   = 32;
  localparam int ADDR_W = 8;

  localparam logic [1:0] LOAD_WORD  = 2'b00;
  localparam logic [1:0] STORE_WORD = 2'b01;
  localparam logic [1:0] ADD        = 2'b10;
  localparam logic [1:0] SUB        = 2'b11;

  localparam logic [SIZE-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HALT     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding {instruction, pc} pairs between memory and control_unit.
// Flush wins over push; the head is read straight from the storage registers.
module fetch_queue #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A push while full is only accepted if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues single outstanding word reads, buffers
// replies in a 2-entry queue and hands one instruction per handshake downstream.
//
// Handshakes: downstream transfer happens on a cycle with instr_valid && instr_ready;
// instruction/instr_pc hold while instr_valid && !instr_ready. Memory side: im_req
// and im_addr hold from issue until the cycle im_ack is sampled high.
module instruction_fetch #(
  parameter int                SIZE      = cpu_pkg::SIZE,
  parameter int                ADDR_W    = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [SIZE-1:0]   HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [SIZE-1:0]   im_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [SIZE-1:0]   instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  import cpu_pkg::*;

  localparam int QW = SIZE + ADDR_W;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              drop;

  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [1:0]        q_count;
  logic [1:0]        free_slots;
  logic [QW-1:0]     q_din;
  logic [QW-1:0]     q_dout;

  // A reply is kept only if it belongs to the current PC stream.
  assign q_push     = (state == WAIT_ACK) && im_ack && !drop && !redirect_valid && !q_full;
  assign q_pop      = instr_valid && instr_ready;
  assign q_din      = {im_rdata, im_addr};
  assign free_slots = 2'd2 - q_count;

  assign instr_valid = !q_empty;
  assign instruction = q_empty ? '0 : q_dout[QW-1:ADDR_W];
  assign instr_pc    = q_empty ? '0 : q_dout[ADDR_W-1:0];
  assign state_dbg   = state;

  fetch_queue #(
    .W (QW)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      im_req  <= 1'b0;
      im_addr <= RESET_PC;
      halted  <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
      // An in-flight read cannot be cancelled, so its reply is marked for discard.
      if (state == WAIT_ACK && !im_ack) begin
        drop <= 1'b1;
      end else begin
        state  <= IDLE;
        im_req <= 1'b0;
        drop   <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (enable && free_slots != 2'd0) begin
            state   <= WAIT_ACK;
            im_req  <= 1'b1;
            im_addr <= pc;
          end
        end
        WAIT_ACK: begin
          if (im_ack) begin
            im_req <= 1'b0;
            if (drop) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              pc <= im_addr + 1'b1;
              if (im_rdata == HALT_WORD) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        HALT: begin
          im_req <= 1'b0;
          halted <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          im_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
